// File: rtl/nbit_ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder/subtractor slice.
// Optional overflow flag is enabled by defining RCA_OVERFLOW_EN.
package nbit_ripple_carry_adder_pkg;

    // Default operand width used by the top and the interface.
    localparam int unsigned RCA_DEFAULT_BITS = 8;

    // Operation select encoding carried on sgn_op2.
    localparam logic RCA_OP_ADD = 1'b0;
    localparam logic RCA_OP_SUB = 1'b1;

endpackage

// File: rtl/nbit_ripple_carry_adder_if.sv
// Operand/result bundle between a datapath master and the adder.
// ovf_o is present only when RCA_OVERFLOW_EN is defined.
interface nbit_ripple_carry_adder_if
    import nbit_ripple_carry_adder_pkg::*;
#(
    parameter int unsigned BIT_NUM = RCA_DEFAULT_BITS
);

    logic [BIT_NUM-1:0] op1;
    logic [BIT_NUM-1:0] op2;
    logic               sgn_op2;
    logic [BIT_NUM-1:0] sum;
    logic               carry_o;
`ifdef RCA_OVERFLOW_EN
    logic               ovf_o;
`endif

    modport master (
        output op1,
        output op2,
        output sgn_op2,
`ifdef RCA_OVERFLOW_EN
        input  ovf_o,
`endif
        input  sum,
        input  carry_o
    );

    modport slave (
        input  op1,
        input  op2,
        input  sgn_op2,
`ifdef RCA_OVERFLOW_EN
        output ovf_o,
`endif
        output sum,
        output carry_o
    );

endinterface

// File: rtl/nbit_ripple_carry_adder_full_adder.sv
// Single-bit full adder cell, chained by the top into a ripple carry.
// Not affected by RCA_OVERFLOW_EN.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic p;

    assign p     = a ^ b;
    assign s     = p ^ c_in;
    assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/nbit_ripple_carry_adder.sv
// N-bit ripple-carry adder/subtractor with one registered result stage.
// Define RCA_OVERFLOW_EN to add the registered signed-overflow flag ovf_o.
module nbit_ripple_carry_adder
    import nbit_ripple_carry_adder_pkg::*;
#(
    parameter int unsigned BIT_NUM = RCA_DEFAULT_BITS
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    nbit_ripple_carry_adder_if.slave    bus
);

    logic [BIT_NUM-1:0] b_eff;
    logic [BIT_NUM:0]   c;
    logic [BIT_NUM-1:0] s;

    logic [BIT_NUM-1:0] sum_d;
    logic [BIT_NUM-1:0] sum_q;
    logic               carry_d;
    logic               carry_q;

    // Subtraction is a + ~b + 1: invert b and seed the chain with 1.
    assign b_eff = bus.op2 ^ {BIT_NUM{bus.sgn_op2}};
    assign c[0]  = bus.sgn_op2;

    for (genvar i = 0; i < BIT_NUM; i++) begin : g_stage
        full_adder u_fa (
            .a     (bus.op1[i]),
            .b     (b_eff[i]),
            .c_in  (c[i]),
            .s     (s[i]),
            .c_out (c[i+1])
        );
    end

    assign sum_d   = s;
    assign carry_d = c[BIT_NUM];

    // Capture sum and carry each cycle; async reset clears them at once.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum     = sum_q;
    assign bus.carry_o = carry_q;

`ifdef RCA_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_d = c[BIT_NUM] ^ c[BIT_NUM-1];

    // Overflow flag registered alongside the sum.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_nbit_ripple_carry_adder.sv
// Directed and random bench for nbit_ripple_carry_adder (BIT_NUM = 8).
// Overflow checks run only when RCA_OVERFLOW_EN is defined.
module tb_nbit_ripple_carry_adder;

    localparam int unsigned W = 8;

    logic clk_i;
    logic arst_i;
    int   checks;
    int   failures;

    nbit_ripple_carry_adder_if #(.BIT_NUM(W)) bus ();

    nbit_ripple_carry_adder #(.BIT_NUM(W)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub);
        @(negedge clk_i);
        bus.op1     = a;
        bus.op2     = b;
        bus.sgn_op2 = sub;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        arst_i      = 1'b1;
        bus.op1     = 8'hAA;
        bus.op2     = 8'h55;
        bus.sgn_op2 = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (bus.sum !== 8'h00 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: sum=%h carry=%b want sum=00 carry=0",
                     bus.sum, bus.carry_o);
        end
`ifdef RCA_OVERFLOW_EN
        checks++;
        if (bus.ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: ovf=%b want 0", bus.ovf_o);
        end
`endif
        @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    task automatic test_add;
        drive(8'h0F, 8'h01, 1'b0);
        checks++;
        if (bus.sum !== 8'h10 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL add_0f_01: sum=%h carry=%b want 10 0",
                     bus.sum, bus.carry_o);
        end
        drive(8'hFF, 8'h01, 1'b0);
        checks++;
        if (bus.sum !== 8'h00 || bus.carry_o !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap: sum=%h carry=%b want 00 1",
                     bus.sum, bus.carry_o);
        end
        drive(8'hA5, 8'h5A, 1'b0);
        checks++;
        if (bus.sum !== 8'hFF || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL add_a5_5a: sum=%h carry=%b want ff 0",
                     bus.sum, bus.carry_o);
        end
    endtask

    task automatic test_sub;
        drive(8'h50, 8'h20, 1'b1);
        checks++;
        if (bus.sum !== 8'h30 || bus.carry_o !== 1'b1) begin
            failures++;
            $display("FAIL sub_50_20: sum=%h carry=%b want 30 1",
                     bus.sum, bus.carry_o);
        end
        drive(8'h20, 8'h50, 1'b1);
        checks++;
        if (bus.sum !== 8'hD0 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow: sum=%h carry=%b want d0 0",
                     bus.sum, bus.carry_o);
        end
        drive(8'h33, 8'h33, 1'b1);
        checks++;
        if (bus.sum !== 8'h00 || bus.carry_o !== 1'b1) begin
            failures++;
            $display("FAIL sub_equal: sum=%h carry=%b want 00 1",
                     bus.sum, bus.carry_o);
        end
    endtask

    task automatic test_back_to_back;
        drive(8'h01, 8'h02, 1'b0);
        checks++;
        if (bus.sum !== 8'h03 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_add: sum=%h carry=%b want 03 0",
                     bus.sum, bus.carry_o);
        end
        drive(8'h01, 8'h02, 1'b1);
        checks++;
        if (bus.sum !== 8'hFF || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sub: sum=%h carry=%b want ff 0",
                     bus.sum, bus.carry_o);
        end
    endtask

    task automatic test_reset_midstream;
        drive(8'h40, 8'h41, 1'b0);
        checks++;
        if (bus.sum !== 8'h81) begin
            failures++;
            $display("FAIL mid_pre: sum=%h want 81", bus.sum);
        end
        @(negedge clk_i);
        arst_i = 1'b1;
        #1;
        checks++;
        if (bus.sum !== 8'h00 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: sum=%h carry=%b want 00 0",
                     bus.sum, bus.carry_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.sum !== 8'h00 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_hold: sum=%h carry=%b want 00 0",
                     bus.sum, bus.carry_o);
        end
        @(negedge clk_i);
        arst_i = 1'b0;
        #1;
        checks++;
        if (bus.sum !== 8'h00) begin
            failures++;
            $display("FAIL mid_release: sum=%h want 00", bus.sum);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.sum !== 8'h81 || bus.carry_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_first: sum=%h carry=%b want 81 0",
                     bus.sum, bus.carry_o);
        end
    endtask

`ifdef RCA_OVERFLOW_EN
    task automatic test_overflow;
        drive(8'h7F, 8'h01, 1'b0);
        checks++;
        if (bus.sum !== 8'h80 || bus.ovf_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_add: sum=%h ovf=%b want 80 1",
                     bus.sum, bus.ovf_o);
        end
        drive(8'h80, 8'h01, 1'b1);
        checks++;
        if (bus.sum !== 8'h7F || bus.ovf_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sub: sum=%h ovf=%b want 7f 1",
                     bus.sum, bus.ovf_o);
        end
        drive(8'h05, 8'h03, 1'b0);
        checks++;
        if (bus.sum !== 8'h08 || bus.ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_none: sum=%h ovf=%b want 08 0",
                     bus.sum, bus.ovf_o);
        end
    endtask
`endif

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W:0]   ref_full;
        int           errs;
        errs = 0;
        for (int n = 0; n < 10000; n++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            if (sub)
                ref_full = {1'b0, a} + {1'b0, ~b} + 9'd1;
            else
                ref_full = {1'b0, a} + {1'b0, b};
            drive(a, b, sub);
            checks++;
            if (bus.sum !== ref_full[W-1:0] ||
                bus.carry_o !== ref_full[W]) begin
                failures++;
                if (errs < 10)
                    $display("FAIL rand a=%h b=%h sub=%b: got %b_%h want %b_%h",
                             a, b, sub, bus.carry_o, bus.sum,
                             ref_full[W], ref_full[W-1:0]);
                errs++;
            end
`ifdef RCA_OVERFLOW_EN
            checks++;
            if (bus.ovf_o !== ((a[W-1] == (b[W-1] ^ sub)) &&
                               (ref_full[W-1] != a[W-1]))) begin
                failures++;
                if (errs < 10)
                    $display("FAIL rand_ovf a=%h b=%h sub=%b: ovf=%b",
                             a, b, sub, bus.ovf_o);
                errs++;
            end
`endif
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midstream();
`ifdef RCA_OVERFLOW_EN
        test_overflow();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
